// File: rtl/matrix_sub_set_seq_if.sv
// rtl/matrix_sub_set_seq_if.sv - set-pair input and result output handshake bundle
interface matrix_sub_set_seq_if #(
  parameter int PARALLEL_NUM = 28
);
  logic                       in_valid;
  logic                       in_ready;
  logic [16*PARALLEL_NUM-1:0] abSet;
  logic [16*PARALLEL_NUM-1:0] bSet;
  logic                       out_valid;
  logic                       out_ready;
  logic [16*PARALLEL_NUM-1:0] aSet;

  modport master (
    output in_valid, abSet, bSet, out_ready,
    input  in_ready, out_valid, aSet
  );

  modport slave (
    input  in_valid, abSet, bSet, out_ready,
    output in_ready, out_valid, aSet
  );
endinterface

// File: rtl/matrix_sub_set_seq.sv
// rtl/matrix_sub_set_seq.sv - lane-wise mod-2^16 set subtractor, LANES_PER_CYCLE lanes per clock
module matrix_sub_set_seq #(
  parameter int PARALLEL_NUM    = 28,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                clk,
  input  logic                rst,
  matrix_sub_set_seq_if.slave bus
);
  localparam int W      = 16 * PARALLEL_NUM;
  localparam int PASSES = PARALLEL_NUM / LANES_PER_CYCLE;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);
  localparam logic [PW-1:0] PASS_ONE  = PW'(1);

  if (PARALLEL_NUM % LANES_PER_CYCLE != 0) begin : g_bad_cfg
    $error("matrix_sub_set_seq: PARALLEL_NUM must be a multiple of LANES_PER_CYCLE");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pass;
  logic [W-1:0]    ab_q, b_q, res_q;
  logic            in_ready_c, out_valid_c;
  logic            last_pass;

  assign last_pass = (pass == LAST_PASS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pass  <= '0;
      ab_q  <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ab_q <= bus.abSet;
            b_q  <= bus.bSet;
            pass <= '0;
          end
        end
        CALC: begin
          // Unsigned 16-bit subtraction wraps naturally, undoing a mod-2^16 add.
          for (int l = 0; l < LANES_PER_CYCLE; l++) begin
            res_q[(int'(pass) * LANES_PER_CYCLE + l) * 16 +: 16] <=
              ab_q[(int'(pass) * LANES_PER_CYCLE + l) * 16 +: 16] -
              b_q[(int'(pass) * LANES_PER_CYCLE + l) * 16 +: 16];
          end
          pass <= last_pass ? '0 : pass + PASS_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_pass) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.aSet      = res_q;
endmodule

// File: tb/tb_matrix_sub_set_seq.sv
// tb/tb_matrix_sub_set_seq.sv - scoreboard bench for matrix_sub_set_seq
module tb_matrix_sub_set_seq;
  localparam int N = 28;
  localparam int W = 16 * N;
  typedef logic [W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   rx_count = 0;
  bit   rand_done = 1'b0;
  vec_t sb[$];

  matrix_sub_set_seq_if #(.PARALLEL_NUM(N)) bus ();

  matrix_sub_set_seq #(.PARALLEL_NUM(N), .LANES_PER_CYCLE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output side: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) check("unexpected_out", 1, 0);
      else check("aset", bus.aSet, sb.pop_front());
      rx_count++;
    end
  end

  task automatic make_pair(output vec_t ab, output vec_t b, output vec_t a);
    logic [15:0] al, bl;
    for (int i = 0; i < N; i++) begin
      al = 16'($urandom);
      bl = 16'($urandom);
      a[i*16 +: 16]  = al;
      b[i*16 +: 16]  = bl;
      ab[i*16 +: 16] = al + bl;
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (bus.in_ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 40);
  endtask

  // Called at posedge+1; returns at posedge+1 with out_valid observed (or timed out).
  task automatic run_one(input string tag, input vec_t ab, input vec_t b, input vec_t exp);
    int lat;
    wait_ready();
    bus.abSet = ab;
    bus.bSet = b;
    bus.in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.abSet = '0;
    bus.bSet = '0;
    wait_out(lat);
    check({tag, "_latency"}, vec_t'(lat), vec_t'(7));
  endtask

  initial begin
    vec_t ab, b, a, ab2, b2, a2, exp;
    int lat, base, budget;
    bit rose;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.abSet = '0;
    bus.bSet = '0;

    #2;
    check("rst_in_ready", vec_t'(bus.in_ready), 1);
    check("rst_out_valid", vec_t'(bus.out_valid), 0);
    check("rst_aset", bus.aSet, '0);
    #1 clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic: every lane recovers 100.
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ab[i*16 +: 16] = 16'(100 + i);
      b[i*16 +: 16]  = 16'(i);
      exp[i*16 +: 16] = 16'h0064;
    end
    run_one("basic", ab, b, exp);
    @(posedge clk); #1;
    check("basic_out_valid_drop", vec_t'(bus.out_valid), 0);
    check("basic_in_ready_back", vec_t'(bus.in_ready), 1);

    // Wrap-around lanes.
    for (int i = 0; i < N; i++) begin
      ab[i*16 +: 16]  = 16'h0000;
      b[i*16 +: 16]   = 16'h0001;
      exp[i*16 +: 16] = 16'hFFFF;
    end
    ab[27*16 +: 16]  = 16'h8000;
    b[27*16 +: 16]   = 16'hFFFF;
    exp[27*16 +: 16] = 16'h8001;
    run_one("wrap", ab, b, exp);
    @(posedge clk); #1;

    // Backpressure with new data waiting at the input.
    bus.out_ready = 1'b0;
    make_pair(ab, b, a);
    make_pair(ab2, b2, a2);
    run_one("bp_first", ab, b, a);
    bus.abSet = ab2;
    bus.bSet = b2;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_valid", vec_t'(bus.out_valid), 1);
      check("bp_in_ready", vec_t'(bus.in_ready), 0);
      check("bp_aset_hold", bus.aSet, a);
      @(posedge clk); #1;
    end
    sb.push_back(a2);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", vec_t'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("bp_second_latency", vec_t'(lat), 7);
    @(posedge clk); #1;

    // Reset during CALC pass 3 discards the set.
    make_pair(ab, b, a);
    bus.abSet = ab;
    bus.bSet = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", vec_t'(bus.out_valid), 0);
    check("midrst_in_ready", vec_t'(bus.in_ready), 1);
    check("midrst_aset", bus.aSet, '0);
    #1 rst = 1'b0;
    rose = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) rose = 1'b1;
    end
    check("midrst_no_output", vec_t'(rose), 0);
    make_pair(ab, b, a);
    run_one("after_rst", ab, b, a);
    @(posedge clk); #1;

    // Random traffic with stalls on both sides.
    check("sb_empty_before_rand", vec_t'(sb.size()), 0);
    base = rx_count;
    fork
      begin
        vec_t rab, rb, ra;
        bit acc;
        int t;
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          make_pair(rab, rb, ra);
          bus.abSet = rab;
          bus.bSet = rb;
          bus.in_valid = 1'b1;
          t = 0;
          forever begin
            acc = (bus.in_ready === 1'b1);
            if (acc) sb.push_back(ra);
            @(posedge clk); #1;
            if (acc) break;
            t++;
            if (t > 200) begin
              check("rand_accept_timeout", 0, 1);
              break;
            end
          end
          bus.in_valid = 1'b0;
        end
      end
      begin
        while (!rand_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join_none
    budget = 0;
    while (rx_count - base < 1000 && budget < 30000) begin
      @(posedge clk); #1;
      budget++;
    end
    rand_done = 1'b1;
    check("rand_count", vec_t'(rx_count - base), 1000);
    check("rand_sb_empty", vec_t'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
